shift_rows_stream: RTL and testbench

Streaming, parametrised ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It accepts one state block per valid/ready handshake and applies the row rotation, forward or inverse, selected per block. Rotation offsets follow Rijndael for block widths of 4, 6 or 8 columns. Results pass through a 2-entry registered buffer so the stage can sit between round pipeline stages with full throughput and backpressure.

---
 rtl/shift_rows_stream.sv | 74 +++++++
 tb/tb_shift_rows_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: streaming AES ShiftRows/InvShiftRows stage with a 2-entry output FIFO.
module shift_rows_stream #(
  parameter int NB = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [32*NB-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inv,
  output logic [CNT_W-1:0]   blocks_done
);
  localparam int W = 32 * NB;
  localparam int S1 = NB == 8 ? 3 : 2;
  localparam int S0 = NB == 8 ? 4 : 3;
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_stream: NB must be 4, 6 or 8");
  end
  logic [W-1:0] fwd_d, inv_d, xf_d;
  // Row shift offsets are constants, so the rotation is pure wiring.
  for (genvar r = 0; r < 4; r++) begin : g_r
    localparam int S = r == 3 ? 0 : r == 2 ? 1 : r == 1 ? S1 : S0;
    for (genvar c = 0; c < NB; c++) begin : g_c
      assign fwd_d[8*(r*NB+c) +: 8] = in_data[8*(r*NB+(c-S+NB)%NB) +: 8];
      assign inv_d[8*(r*NB+c) +: 8] = in_data[8*(r*NB+(c+S)%NB) +: 8];
    end
  end
  assign xf_d = in_inv ? inv_d : fwd_d;
  logic [W-1:0] mem_d [2];
  logic [TAG_W-1:0] mem_t [2];
  logic [1:0] mem_i;
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  assign in_ready = cnt != 2'd2 && rst_n;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_data = rp ? mem_d[1] : mem_d[0];
  assign out_tag = rp ? mem_t[1] : mem_t[0];
  assign out_inv = mem_i[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_d[0] <= '0;
      mem_d[1] <= '0;
      mem_t[0] <= '0;
      mem_t[1] <= '0;
      mem_i <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      blocks_done <= '0;
    end else begin
      if (push) begin
        mem_d[wp] <= xf_d;
        mem_t[wp] <= in_tag;
        mem_i[wp] <= in_inv;
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        blocks_done <= blocks_done + CNT_W'(1);
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: randomized + directed scoreboard bench for NB=4/6/8 instances.
module tb_shift_rows_stream;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [3:0] in_tag = '0;
  logic [255:0] din = '0;
  always #5 clk = ~clk;
  logic rdy4, ov4, oi4, rdy6, ov6, oi6, rdy8, ov8, oi8;
  logic [127:0] od4;
  logic [191:0] od6;
  logic [255:0] od8;
  logic [3:0] ot4, ot6, ot8, bd4;
  logic [15:0] bd6, bd8;
  shift_rows_stream #(.NB(4), .TAG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .in_inv(in_inv),
    .in_tag(in_tag), .in_data(din[127:0]), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_tag(ot4), .out_inv(oi4), .blocks_done(bd4));
  shift_rows_stream #(.NB(6), .TAG_W(4), .CNT_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6), .in_inv(in_inv),
    .in_tag(in_tag), .in_data(din[191:0]), .out_valid(ov6), .out_ready(1'b1),
    .out_data(od6), .out_tag(ot6), .out_inv(oi6), .blocks_done(bd6));
  shift_rows_stream #(.NB(8), .TAG_W(4), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .in_inv(in_inv),
    .in_tag(in_tag), .in_data(din), .out_valid(ov8), .out_ready(1'b1),
    .out_data(od8), .out_tag(ot8), .out_inv(oi8), .blocks_done(bd8));
  typedef struct packed {logic [255:0] d; logic [3:0] t; logic i;} exp_t;
  exp_t q4[$], q6[$], q8[$];
  exp_t e4, e6, e8;
  int n_chk = 0, n_fail = 0;
  logic [3:0] bd_m = '0;
  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference: rotate each row one byte at a time, s(r) times.
  function automatic logic [255:0] ref_sr(input logic [255:0] x, input int nb, input logic inv);
    logic [7:0] row [8];
    logic [7:0] t;
    int s;
    ref_sr = '0;
    for (int r = 0; r < 4; r++) begin
      s = r == 3 ? 0 : r == 2 ? 1 : r == 1 ? (nb == 8 ? 3 : 2) : (nb == 8 ? 4 : 3);
      for (int c = 0; c < nb; c++) row[c] = x[8*(r*nb+c) +: 8];
      for (int k = 0; k < s; k++) begin
        if (!inv) begin
          t = row[nb-1];
          for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
          row[0] = t;
        end else begin
          t = row[0];
          for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
          row[nb-1] = t;
        end
      end
      for (int c = 0; c < nb; c++) ref_sr[8*(r*nb+c) +: 8] = row[c];
    end
  endfunction
  function automatic logic [255:0] rnd256();
    for (int k = 0; k < 8; k++) rnd256[32*k +: 32] = $urandom();
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      bd_m = '0;
    end else begin
      chk(bd4 == bd_m, "blocks_done", 256'(bd4), 256'(bd_m));
      if (ov4 && out_ready) begin
        chk(q4.size() > 0, "out4 expected", od4, 0);
        if (q4.size() > 0) begin
          e4 = q4.pop_front();
          chk({od4, ot4, oi4} == {e4.d[127:0], e4.t, e4.i}, "out4", {od4, ot4, oi4}, {e4.d[127:0], e4.t, e4.i});
        end
        bd_m++;
      end
      if (in_valid && rdy4) q4.push_back('{d: ref_sr(din, 4, in_inv), t: in_tag, i: in_inv});
    end
  end
  always @(negedge clk) begin
    if (!rst_n) q6.delete();
    else begin
      if (ov6) begin
        chk(q6.size() > 0, "out6 expected", od6, 0);
        if (q6.size() > 0) begin
          e6 = q6.pop_front();
          chk({od6, ot6, oi6} == {e6.d[191:0], e6.t, e6.i}, "out6", {od6, ot6, oi6}, {e6.d[191:0], e6.t, e6.i});
        end
      end
      if (in_valid && rdy6) q6.push_back('{d: ref_sr(din, 6, in_inv), t: in_tag, i: in_inv});
    end
  end
  always @(negedge clk) begin
    if (!rst_n) q8.delete();
    else begin
      if (ov8) begin
        chk(q8.size() > 0, "out8 expected", od8, 0);
        if (q8.size() > 0) begin
          e8 = q8.pop_front();
          chk(od8 == e8.d && ot8 == e8.t && oi8 == e8.i, "out8", od8, e8.d);
        end
      end
      if (in_valid && rdy8) q8.push_back('{d: ref_sr(din, 8, in_inv), t: in_tag, i: in_inv});
    end
  end
  task automatic send(input logic [255:0] d, input logic inv, input logic [3:0] tag);
    logic r;
    bit ok;
    ok = 1'b0;
    din = d;
    in_inv = inv;
    in_tag = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = rdy4;
      @(posedge clk);
      #1;
      ok = r;
    end
    chk(ok, "send accept", 256'(ok), 1);
  endtask
  initial begin
    logic [255:0] a, b;
    logic [3:0] bd0;
    repeat (3) @(posedge clk);
    #1;
    chk(ov4 == 1'b0, "rst out_valid", 256'(ov4), 0);
    chk(rdy4 == 1'b0, "rst in_ready", 256'(rdy4), 0);
    chk(bd4 == 4'd0, "rst blocks_done", 256'(bd4), 0);
    chk(od4 == '0 && ot4 == '0 && oi4 == 1'b0, "rst out_data", od4, 0);
    rst_n = 1'b1;
    #1;
    chk(rdy4 == 1'b1, "ready after reset", 256'(rdy4), 1);
    out_ready = 1'b1;
    a = '0;
    a[127:0] = 128'h33323130_23222120_13121110_03020100;
    send(a, 1'b0, 4'd3);
    in_valid = 1'b0;
    chk(ov4 == 1'b1, "fwd4 latency", 256'(ov4), 1);
    chk(od4 == 128'h33323130_22212023_11101312_00030201, "fwd4 data", od4, 128'h33323130_22212023_11101312_00030201);
    b = 256'(od4);
    send(b, 1'b1, 4'd5);
    in_valid = 1'b0;
    chk(od4 == a[127:0], "round trip data", od4, a[127:0]);
    chk(ot4 == 4'd5 && oi4 == 1'b1, "round trip tag/inv", {ot4, oi4}, {4'd5, 1'b1});
    a = '0;
    for (int c = 0; c < 8; c++) begin
      a[8*c +: 8] = 8'(c);
      a[8*(8+c) +: 8] = 8'(8'h10 + c);
    end
    send(a, 1'b0, 4'd7);
    in_valid = 1'b0;
    chk(ov8 && od8[63:0] == 64'h03020100_07060504, "fwd8 row0", od8[63:0], 64'h03020100_07060504);
    chk(od8[127:64] == 64'h14131211_10171615, "fwd8 row1", od8[127:64], 64'h14131211_10171615);
    chk(ov6 && od6[47:0] == 48'h0201_0005_0403, "fwd6 row0", od6[47:0], 48'h0201_0005_0403);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    bd0 = bd4;
    send(rnd256(), 1'b0, 4'd0);
    send(rnd256(), 1'b1, 4'd1);
    din = rnd256();
    in_tag = 4'd2;
    chk(rdy4 == 1'b0, "bp in_ready low", 256'(rdy4), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk(ov4 && ot4 == 4'd0 && !rdy4, "bp hold head", {ov4, ot4, rdy4}, {1'b1, 4'd0, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk(rdy4 && ot4 == 4'd1, "bp ready rise", {rdy4, ot4}, {1'b1, 4'd1});
    send(din, in_inv, 4'd2);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(bd4 == 4'(bd0 + 4'd3) && !ov4, "bp drained count", 256'(bd4), 256'(4'(bd0 + 4'd3)));
    out_ready = 1'b0;
    send(rnd256(), 1'b0, 4'd4);
    send(rnd256(), 1'b0, 4'd6);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk(!ov4 && bd4 == 4'd0, "midrst state", {ov4, bd4}, 0);
    chk(od4 == '0 && ot4 == '0 && !oi4, "midrst out_data", od4, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(rnd256(), 1'b1, 4'd9);
    in_valid = 1'b0;
    chk(ov4 && ot4 == 4'd9 && oi4, "post reset block", {ov4, ot4, oi4}, {1'b1, 4'd9, 1'b1});
    @(posedge clk);
    #1;
    chk(!ov4, "post reset alone", 256'(ov4), 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(rnd256(), 1'($urandom()), 4'($urandom()));
      chk(rdy4 == 1'b1, "throughput ready", 256'(rdy4), 1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk(bd4 == 4'd15, "wrap 15", 256'(bd4), 15);
    send(rnd256(), 1'b0, 4'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk(bd4 == 4'd0, "wrap 0", 256'(bd4), 0);
    send(rnd256(), 1'b1, 4'd2);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk(bd4 == 4'd1, "wrap 1", 256'(bd4), 1);
    repeat (400) begin
      din = rnd256();
      in_tag = 4'($urandom());
      in_inv = 1'($urandom());
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(q4.size() == 0 && q6.size() == 0 && q8.size() == 0, "queues drained", 256'(q4.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
